// File: rtl/store_wbuffer_responder_pkg.sv
// Shared types for the store write buffer: entry record, drain FSM states,
// word-offset constant and the byte-lane merge helper.
package store_wbuffer_responder_pkg;

    localparam int WBUF_WORD_OFFSET = 3;
    localparam int WBUF_PLEN        = 56;
    localparam int WBUF_WADDR_W     = WBUF_PLEN - WBUF_WORD_OFFSET;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } wbuf_state_e;

    typedef struct packed {
        logic [WBUF_WADDR_W-1:0] waddr;
        logic [63:0]             data;
        logic [7:0]              be;
        logic                    valid;
        logic                    inflight;
    } wbuf_entry_t;

    // Overwrite only the byte lanes whose enable is set.
    function automatic logic [63:0] wbuf_merge_bytes(input logic [63:0] old_data,
                                                     input logic [63:0] new_data,
                                                     input logic [7:0]  be);
        logic [63:0] merged;
        merged = old_data;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) merged[8*b +: 8] = new_data[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/store_wbuffer_responder_if.sv
// Store-port and memory-port bundle of the write buffer; slave is the
// responder's view, master is the store-buffer / memory side.
interface store_wbuffer_responder_if #(
    parameter int PLEN    = 56,
    parameter int INDEX_W = 12
);
    logic                  data_req_i;
    logic                  data_we_i;
    logic [INDEX_W-1:0]    address_index_i;
    logic [PLEN-INDEX_W-1:0] address_tag_i;
    logic [63:0]           data_wdata_i;
    logic [7:0]            data_be_i;
    logic [1:0]            data_size_i;
    logic [2:0]            data_id_i;
    logic                  data_gnt_o;
    logic                  data_rvalid_o;
    logic [2:0]            data_rid_o;

    logic                  mem_req_o;
    logic                  mem_gnt_i;
    logic                  mem_ack_i;
    logic [PLEN-1:0]       mem_addr_o;
    logic [63:0]           mem_wdata_o;
    logic [7:0]            mem_be_o;

    logic                  empty_o;

    // Handshakes: a store is taken in any cycle where data_req_i and
    // data_gnt_o are both high (gnt is combinational, no retry state);
    // data_rvalid_o follows one cycle later. A memory write is taken when
    // mem_req_o and mem_gnt_i are both high; mem_req_o and its payload stay
    // stable until then. mem_ack_i completes it, either with the gnt or later.
    modport slave (
        input  data_req_i, data_we_i, address_index_i, address_tag_i,
               data_wdata_i, data_be_i, data_size_i, data_id_i,
        output data_gnt_o, data_rvalid_o, data_rid_o,
        output mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_gnt_i, mem_ack_i,
        output empty_o
    );

    modport master (
        output data_req_i, data_we_i, address_index_i, address_tag_i,
               data_wdata_i, data_be_i, data_size_i, data_id_i,
        input  data_gnt_o, data_rvalid_o, data_rid_o,
        input  mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_gnt_i, mem_ack_i,
        input  empty_o
    );
endinterface

// File: rtl/store_wbuffer_responder_match.sv
// Word-address match of an incoming store against all mergeable entries;
// returns a one-hot hit (lowest index wins) and an any-hit flag.
module wbuf_match
    import store_wbuffer_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [WBUF_WADDR_W-1:0] waddr_i,
    input  logic [WBUF_WADDR_W-1:0] entry_waddr_i [DEPTH],
    input  logic [DEPTH-1:0]        entry_valid_i,
    input  logic [DEPTH-1:0]        entry_inflight_i,
    output logic [DEPTH-1:0]        hit_o,
    output logic                    any_hit_o
);

    logic [DEPTH-1:0] raw_hit;

    always_comb begin
        raw_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            raw_hit[i] = entry_valid_i[i] & ~entry_inflight_i[i] &
                         (entry_waddr_i[i] == waddr_i);
        end
    end

    // Isolate the lowest set bit so the result is one-hot even if the
    // single-hit invariant were ever broken.
    assign hit_o     = raw_hit & (~raw_hit + DEPTH'(1));
    assign any_hit_o = |raw_hit;

endmodule

// File: rtl/store_wbuffer_responder.sv
// Core-side D$ store responder: grants stores into a small in-order write
// buffer and drains it to a req/gnt/ack memory port. Coalescing of stores to
// the same 64-bit word is enabled by defining WBUF_MERGE_EN.
module store_wbuffer_responder
    import store_wbuffer_responder_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PLEN    = WBUF_PLEN,
    parameter int XLEN    = 64,
    parameter int INDEX_W = 12
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    store_wbuffer_responder_if.slave    bus,
    output wbuf_state_e                 dbg_state_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (PLEN != WBUF_PLEN || XLEN != 64 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("store_wbuffer_responder: unsupported DEPTH/PLEN/XLEN combination");
    end

    wbuf_entry_t             wbuf_q [DEPTH];
    logic [PTR_W-1:0]        head_q, tail_q;
    logic [CNT_W-1:0]        count_q;
    wbuf_state_e             state_q, state_d;
    logic                    rvalid_q;
    logic [2:0]              rid_q;

    logic [PLEN-1:0]         paddr;
    logic [WBUF_WADDR_W-1:0] req_waddr;
    logic                    unused_bits;
    logic [DEPTH-1:0]        hit_vec;
    logic                    merge_hit;
    logic [PTR_W-1:0]        hit_idx;
    logic                    full;
    logic                    gnt, alloc, do_merge;
    logic                    mark_inflight, retire, mem_req;

    assign paddr       = {bus.address_tag_i, bus.address_index_i};
    assign req_waddr   = paddr[PLEN-1:WBUF_WORD_OFFSET];
    assign unused_bits = ^{paddr[WBUF_WORD_OFFSET-1:0], bus.data_size_i};

`ifdef WBUF_MERGE_EN
    logic [WBUF_WADDR_W-1:0] entry_waddr [DEPTH];
    logic [DEPTH-1:0]        entry_valid, entry_inflight;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_waddr[i]    = wbuf_q[i].waddr;
            entry_valid[i]    = wbuf_q[i].valid;
            entry_inflight[i] = wbuf_q[i].inflight;
        end
    end

    wbuf_match #(.DEPTH(DEPTH)) u_match (
        .waddr_i          (req_waddr),
        .entry_waddr_i    (entry_waddr),
        .entry_valid_i    (entry_valid),
        .entry_inflight_i (entry_inflight),
        .hit_o            (hit_vec),
        .any_hit_o        (merge_hit)
    );
`else
    assign hit_vec   = '0;
    assign merge_hit = 1'b0;
`endif

    always_comb begin
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_idx = PTR_W'(i);
        end
    end

    // A full buffer refuses even when the head retires this cycle.
    assign full     = (count_q == CNT_W'(DEPTH));
    assign gnt      = bus.data_req_i & bus.data_we_i & (merge_hit | ~full);
    assign alloc    = gnt & ~merge_hit;
    assign do_merge = gnt & merge_hit;

    always_comb begin
        state_d       = state_q;
        mark_inflight = 1'b0;
        retire        = 1'b0;
        mem_req       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    mark_inflight = 1'b1;
                    state_d       = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (bus.mem_gnt_i) begin
                    if (bus.mem_ack_i) begin
                        retire  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.mem_ack_i) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Alloc never targets the head while it is retiring: tail==head only
    // when the buffer is empty (nothing to retire) or full (no alloc).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) wbuf_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc) begin
                wbuf_q[tail_q] <= '{waddr:    req_waddr,
                                    data:     bus.data_wdata_i,
                                    be:       bus.data_be_i,
                                    valid:    1'b1,
                                    inflight: 1'b0};
                tail_q <= tail_q + PTR_W'(1);
            end
            if (do_merge) begin
                wbuf_q[hit_idx].data <= wbuf_merge_bytes(wbuf_q[hit_idx].data,
                                                         bus.data_wdata_i, bus.data_be_i);
                wbuf_q[hit_idx].be   <= wbuf_q[hit_idx].be | bus.data_be_i;
            end
            if (mark_inflight) wbuf_q[head_q].inflight <= 1'b1;
            if (retire) begin
                wbuf_q[head_q].valid    <= 1'b0;
                wbuf_q[head_q].inflight <= 1'b0;
                head_q                  <= head_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(alloc) - CNT_W'(retire);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rid_q    <= '0;
        end else begin
            rvalid_q <= gnt;
            if (gnt) rid_q <= bus.data_id_i;
        end
    end

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = rvalid_q;
    assign bus.data_rid_o    = rid_q;
    assign bus.mem_req_o     = mem_req;
    assign bus.mem_addr_o    = mem_req ? {wbuf_q[head_q].waddr, {WBUF_WORD_OFFSET{1'b0}}} : '0;
    assign bus.mem_wdata_o   = mem_req ? wbuf_q[head_q].data : '0;
    assign bus.mem_be_o      = mem_req ? wbuf_q[head_q].be : '0;
    assign bus.empty_o       = (count_q == '0) && (state_q == IDLE);
    assign dbg_state_o       = state_q;

    a_req_is_write: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.data_req_i |-> bus.data_we_i);

    a_head_draining: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q != IDLE) |-> (wbuf_q[head_q].valid && wbuf_q[head_q].inflight));

endmodule

// File: tb/tb_store_wbuffer_responder.sv
// Directed bench for store_wbuffer_responder: store-port vectors plus a
// memory-side scoreboard of expected {addr, be, data} writes.
module tb_store_wbuffer_responder;
    import store_wbuffer_responder_pkg::*;

    localparam int PLEN    = 56;
    localparam int INDEX_W = 12;
    localparam int DEPTH   = 4;

    typedef struct {
        logic [55:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
        logic [2:0]  id;
        logic        exp_gnt;
    } vec_t;

    logic        clk, rst_n;
    logic        mem_auto, gnt_man, ack_man, gnt_s;
    wbuf_state_e dbg_state;
    int          tests, fails;
    logic [127:0] exp_q[$];
    vec_t        full_v [5];

    store_wbuffer_responder_if #(.PLEN(PLEN), .INDEX_W(INDEX_W)) bus ();

    assign bus.mem_gnt_i = mem_auto ? bus.mem_req_o : gnt_man;
    assign bus.mem_ack_i = mem_auto ? bus.mem_req_o : ack_man;

    store_wbuffer_responder #(
        .DEPTH(DEPTH), .PLEN(PLEN), .XLEN(64), .INDEX_W(INDEX_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input logic [55:0] addr, input logic [7:0] be,
                                     input logic [63:0] data);
        exp_q.push_back({addr, be, data});
    endfunction

    task automatic mon_check();
        logic [127:0] act, exp;
        if (rst_n && bus.mem_req_o && bus.mem_gnt_i) begin
            act = {bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL mem_write: got unexpected write 0x%0h expected none", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    fails++;
                    $display("FAIL mem_write: got 0x%0h expected 0x%0h", act, exp);
                end
            end
        end
    endtask

    // One cycle: sample combinational outputs and the memory port mid-cycle,
    // then land 1 ns after the next rising edge.
    task automatic tick();
        @(negedge clk);
        gnt_s = bus.data_gnt_o;
        mon_check();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [55:0] addr, input logic [7:0] be,
                               input logic [63:0] data, input logic [2:0] id);
        bus.data_req_i      = 1'b1;
        bus.data_we_i       = 1'b1;
        bus.address_tag_i   = addr[55:12];
        bus.address_index_i = addr[11:0];
        bus.data_wdata_i    = data;
        bus.data_be_i       = be;
        bus.data_size_i     = 2'd3;
        bus.data_id_i       = id;
    endtask

    task automatic store(input string tag, input logic [55:0] addr, input logic [7:0] be,
                         input logic [63:0] data, input logic [2:0] id, input logic exp_gnt);
        drive_store(addr, be, data, id);
        tick();
        bus.data_req_i = 1'b0;
        chk({tag, "_gnt"}, gnt_s, exp_gnt);
        chk({tag, "_rvalid"}, bus.data_rvalid_o, exp_gnt);
        if (exp_gnt) chk({tag, "_rid"}, bus.data_rid_o, id);
    endtask

    task automatic store_retry(input string tag, input logic [55:0] addr, input logic [7:0] be,
                               input logic [63:0] data, input logic [2:0] id);
        logic got;
        got = 1'b0;
        for (int a = 0; a < 16 && !got; a++) begin
            drive_store(addr, be, data, id);
            tick();
            got = gnt_s;
        end
        bus.data_req_i = 1'b0;
        chk({tag, "_granted"}, got, 1'b1);
        chk({tag, "_rvalid"}, bus.data_rvalid_o, 1'b1);
        chk({tag, "_rid"}, bus.data_rid_o, id);
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.empty_o && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_empty"}, bus.empty_o, 1'b1);
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, bus.data_gnt_o, 1'b0);
        chk({tag, "_rvalid"}, bus.data_rvalid_o, 1'b0);
        chk({tag, "_rid"}, bus.data_rid_o, 3'd0);
        chk({tag, "_mem_req"}, bus.mem_req_o, 1'b0);
        chk({tag, "_mem_addr"}, bus.mem_addr_o, 56'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata_o, 64'd0);
        chk({tag, "_mem_be"}, bus.mem_be_o, 8'd0);
        chk({tag, "_empty"}, bus.empty_o, 1'b1);
        chk({tag, "_state"}, dbg_state, IDLE);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        mem_auto = 1'b0;
        gnt_man = 1'b0;
        ack_man = 1'b0;
        gnt_s = 1'b0;
        bus.data_req_i = 1'b0;
        bus.data_we_i = 1'b0;
        bus.address_tag_i = '0;
        bus.address_index_i = '0;
        bus.data_wdata_i = '0;
        bus.data_be_i = '0;
        bus.data_size_i = '0;
        bus.data_id_i = '0;

        full_v[0] = '{56'h1000, 8'hFF, 64'hA000_0000_0000_1000, 3'd2, 1'b1};
        full_v[1] = '{56'h1008, 8'hFF, 64'hA000_0000_0000_1008, 3'd3, 1'b1};
        full_v[2] = '{56'h1010, 8'hFF, 64'hA000_0000_0000_1010, 3'd4, 1'b1};
        full_v[3] = '{56'h1018, 8'hFF, 64'hA000_0000_0000_1018, 3'd5, 1'b1};
        full_v[4] = '{56'h1020, 8'hFF, 64'hA000_0000_0000_1020, 3'd6, 1'b0};

        // Reset state
        #12;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single store: gnt now, rvalid next, mem_req two cycles after gnt
        push_exp(56'h8000_0010, 8'h0F, 64'h1122_3344);
        store("single", 56'h8000_0010, 8'h0F, 64'h1122_3344, 3'd1, 1'b1);
        chk("single_req_n1", bus.mem_req_o, 1'b0);
        chk("single_not_empty", bus.empty_o, 1'b0);
        tick();
        chk("single_req_n2", bus.mem_req_o, 1'b1);
        chk("single_addr", bus.mem_addr_o, 56'h8000_0010);
        chk("single_be", bus.mem_be_o, 8'h0F);
        chk("single_wdata", bus.mem_wdata_o, 64'h1122_3344);
        gnt_man = 1'b1;
        tick();
        gnt_man = 1'b0;
        chk("single_wait", dbg_state, WAIT);
        chk("single_wait_req", bus.mem_req_o, 1'b0);
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        chk("single_empty", bus.empty_o, 1'b1);
        chk("single_drained", exp_q.size(), 0);

        // Merge: head goes inflight, later same-word stores coalesce
        push_exp(56'h100, 8'h01, 64'hAA);
`ifdef WBUF_MERGE_EN
        push_exp(56'h108, 8'h03, 64'hCCBB);
`else
        push_exp(56'h108, 8'h01, 64'hBB);
        push_exp(56'h108, 8'h02, 64'hCC00);
`endif
        store("merge0", 56'h100, 8'h01, 64'hAA, 3'd1, 1'b1);
        store("merge1", 56'h108, 8'h01, 64'hBB, 3'd2, 1'b1);
        store("merge2", 56'h108, 8'h02, 64'hCC00, 3'd3, 1'b1);
        chk("merge_state", dbg_state, REQ);
        chk("merge_head_addr", bus.mem_addr_o, 56'h100);
        chk("merge_head_be", bus.mem_be_o, 8'h01);
        mem_auto = 1'b1;
        wait_empty("merge", 30);
        mem_auto = 1'b0;

        // Full: four grants, fifth refused; a retire frees one slot
        for (int i = 0; i < 4; i++) push_exp(full_v[i].addr, full_v[i].be, full_v[i].data);
        push_exp(56'h1020, 8'hFF, 64'hA000_0000_0000_1020);
        push_exp(56'h1028, 8'hFF, 64'hA000_0000_0000_1028);
        for (int i = 0; i < 5; i++) begin
            store($sformatf("full%0d", i), full_v[i].addr, full_v[i].be, full_v[i].data,
                  full_v[i].id, full_v[i].exp_gnt);
        end
        chk("full_req_held", bus.mem_req_o, 1'b1);
        chk("full_addr_held", bus.mem_addr_o, 56'h1000);
        gnt_man = 1'b1;
        ack_man = 1'b1;
        tick();
        gnt_man = 1'b0;
        ack_man = 1'b0;
        store("full_after_ack", 56'h1020, 8'hFF, 64'hA000_0000_0000_1020, 3'd7, 1'b1);
        // Full again; the head retiring this cycle must not open a slot
        gnt_man = 1'b1;
        ack_man = 1'b1;
        store("full_no_bypass", 56'h1028, 8'hFF, 64'hA000_0000_0000_1028, 3'd0, 1'b0);
        gnt_man = 1'b0;
        ack_man = 1'b0;
        store("full_retry", 56'h1028, 8'hFF, 64'hA000_0000_0000_1028, 3'd1, 1'b1);
        mem_auto = 1'b1;
        wait_empty("full", 40);
        mem_auto = 1'b0;

        // Inflight protection: same word while head is in REQ allocates anew
        push_exp(56'h200, 8'h0F, 64'h0000_0000_0102_0304);
        push_exp(56'h200, 8'hF0, 64'h0506_0708_0000_0000);
        store("inflt0", 56'h200, 8'h0F, 64'h0000_0000_0102_0304, 3'd7, 1'b1);
        tick();
        chk("inflt_state", dbg_state, REQ);
        store("inflt1", 56'h200, 8'hF0, 64'h0506_0708_0000_0000, 3'd0, 1'b1);
        chk("inflt_head_be", bus.mem_be_o, 8'h0F);
        mem_auto = 1'b1;
        wait_empty("inflt", 30);

        // Wrap-around: ten stores against an always-ready memory
        for (int i = 0; i < 10; i++) begin
            push_exp(56'h3000 + 56'(8 * i), 8'hFF, 64'h1111_0000_0000_0000 + 64'(i));
        end
        for (int i = 0; i < 10; i++) begin
            store_retry($sformatf("wrap%0d", i), 56'h3000 + 56'(8 * i), 8'hFF,
                        64'h1111_0000_0000_0000 + 64'(i), 3'(i));
        end
        wait_empty("wrap", 60);
        mem_auto = 1'b0;

        // Async reset while draining in WAIT
        push_exp(56'h400, 8'hFF, 64'h4444);
        store("rst0", 56'h400, 8'hFF, 64'h4444, 3'd3, 1'b1);
        tick();
        gnt_man = 1'b1;
        tick();
        gnt_man = 1'b0;
        chk("rst_in_wait", dbg_state, WAIT);
        store("rst1", 56'h408, 8'hFF, 64'h5555, 3'd6, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_async");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_after_req", bus.mem_req_o, 1'b0);
        chk("rst_after_empty", bus.empty_o, 1'b1);
        chk("rst_after_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
